// File: rtl/npu_pkg.sv
// Shared NPU definitions: drain FSM state encoding and default skid-buffer depth.
package npu_pkg;

    typedef enum logic [1:0] {
        DRAIN_IDLE  = 2'd0,
        DRAIN_READ  = 2'd1,
        DRAIN_DRAIN = 2'd2
    } drain_state_t;

    localparam int unsigned DRAIN_FIFO_DEPTH = 4;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_wr    = i_push & ~o_full;
    assign w_rd    = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/sram_c_drain.sv
// Streams a block of SRAM C bytes out through a skid FIFO toward the SPI transmit side.
module sram_c_drain
    import npu_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = DRAIN_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    output logic [ADDR_W-1:0] sram_c_addr,
    output logic              sram_c_re,
    input  logic [DATA_W-1:0] sram_c_dout,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH);

    drain_state_t      r_state;
    drain_state_t      w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_re;
    logic              r_re_q;
    logic              r_done;
    logic              w_issue;
    logic              w_done_next;
    logic              w_flush;
    logic              w_load;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CW:0]       w_count;
    logic [CW+1:0]     w_pending;
    logic [DATA_W-1:0] w_head;

    // r_re marks a read the SRAM has not yet sampled, r_re_q a byte on sram_c_dout
    // awaiting its push; both are reserved FIFO slots.
    assign w_pending = (CW+2)'(w_count) + (CW+2)'(r_re) + (CW+2)'(r_re_q);
    assign w_push    = r_re_q & ~w_full;
    assign w_pop     = out_valid & out_ready;

    assign sram_c_addr = r_addr;
    assign sram_c_re   = r_re;
    assign out_valid   = ~w_empty;
    assign out_data    = w_empty ? '0 : w_head;
    assign busy        = (r_state != DRAIN_IDLE);
    assign done        = r_done;

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        w_issue      = 1'b0;
        w_flush      = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            DRAIN_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        w_load       = 1'b1;
                        w_state_next = DRAIN_READ;
                    end else begin
                        w_done_next  = 1'b1;
                    end
                end
            end
            DRAIN_READ: begin
                if (abort) begin
                    w_flush      = 1'b1;
                    w_done_next  = 1'b1;
                    w_state_next = DRAIN_IDLE;
                end else if (r_remaining == '0) begin
                    w_state_next = DRAIN_DRAIN;
                end else begin
                    w_issue = (w_pending < (CW+2)'(FIFO_DEPTH));
                end
            end
            DRAIN_DRAIN: begin
                if (abort) begin
                    w_flush      = 1'b1;
                    w_done_next  = 1'b1;
                    w_state_next = DRAIN_IDLE;
                end else if (w_pop && (w_count == (CW+1)'(1)) && !r_re_q) begin
                    w_done_next  = 1'b1;
                    w_state_next = DRAIN_IDLE;
                end
            end
            default: w_state_next = DRAIN_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= DRAIN_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_re        <= 1'b0;
            r_re_q      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
            r_re    <= w_issue;
            r_re_q  <= r_re & ~w_flush;
            if (w_load) begin
                r_addr      <= base_addr;
                r_remaining <= length;
            end else begin
                if (r_re)    r_addr      <= r_addr + ADDR_W'(1);
                if (w_issue) r_remaining <= r_remaining - (ADDR_W+1)'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  (sram_c_dout),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_sram_c_drain.sv
// Scoreboard bench for sram_c_drain: SRAM C model, expected bytes/addresses queued at start.
module tb_sram_c_drain;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          abort = 1'b0;
    logic [AW-1:0] sram_c_addr;
    logic          sram_c_re;
    logic [DW-1:0] sram_c_dout = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] exp_data [$];
    logic [AW-1:0] exp_addr [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int done_cnt, done_cyc, first_valid, first_pop, last_pop, pop_cnt;
    int re_cnt, re_first, re_last;
    bit busy_seen, prev_stall;
    logic [DW-1:0] prev_data;

    sram_c_drain #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .abort       (abort),
        .sram_c_addr (sram_c_addr),
        .sram_c_re   (sram_c_re),
        .sram_c_dout (sram_c_dout),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (sram_c_re) sram_c_dout <= mem[sram_c_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        done_cnt    = 0;
        done_cyc    = -1;
        first_valid = -1;
        first_pop   = -1;
        last_pop    = -1;
        pop_cnt     = 0;
        re_cnt      = 0;
        re_first    = -1;
        re_last     = -1;
        busy_seen   = 1'b0;
        prev_stall  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_seen = 1'b1;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (sram_c_re) begin
                re_cnt++;
                if (re_first < 0) re_first = cyc;
                re_last = cyc;
                check_eq("re_while_busy", busy, 1);
                check_eq("read_expected", exp_addr.size() != 0, 1);
                if (exp_addr.size() != 0) check_eq("sram_addr", sram_c_addr, exp_addr.pop_front());
            end
            if (prev_stall) begin
                check_eq("stall_valid", out_valid, 1);
                check_eq("stall_data", out_data, prev_data);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready) begin
                pop_cnt++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                check_eq("byte_expected", exp_data.size() != 0, 1);
                if (exp_data.size() != 0) check_eq("out_data", out_data, exp_data.pop_front());
            end
        end
    end

    // Queues the expected stream, then pulses start; returns with t0 = start edge.
    task automatic start_drain(input logic [AW-1:0] base, input logic [AW:0] len,
                               input bit with_abort, output int t0);
        logic [AW-1:0] a;
        clear_stats();
        for (int unsigned i = 0; i < len; i++) begin
            a = base + AW'(i);
            exp_addr.push_back(a);
            exp_data.push_back(mem[a]);
        end
        @(posedge clk); #1;
        base_addr = base;
        length    = len;
        start     = 1'b1;
        abort     = with_abort;
        @(posedge clk); #1;
        t0    = cyc;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic run_drain(input logic [AW-1:0] base, input logic [AW:0] len,
                             input bit toggle, input bit with_abort);
        int t0;
        start_drain(base, len, with_abort, t0);
        for (int k = 0; k < 400 && done_cnt == 0; k++) begin
            @(posedge clk); #1;
            if (toggle) out_ready = ~out_ready;
            if (toggle && k == 5) begin
                start     = 1'b1;
                base_addr = '0;
                length    = 3;
            end else begin
                start = 1'b0;
            end
        end
        out_ready = 1'b1;
        start     = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_eq("done_pulses", done_cnt, 1);
        check_eq("bytes_left", exp_data.size(), 0);
        check_eq("reads_left", exp_addr.size(), 0);
        check_eq("read_count", re_cnt, len);
        check_eq("byte_count", pop_cnt, len);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_valid", out_valid, 0);
        if (len == 0) begin
            check_eq("len0_busy_seen", busy_seen, 0);
            check_eq("len0_done_lat", done_cyc - t0, 0);
        end else if (!toggle) begin
            check_eq("first_valid_lat", first_valid - t0, 3);
            check_eq("done_lat", done_cyc - t0, len + 3);
            check_eq("pop_span", last_pop - first_pop, len - 1);
        end else begin
            check_eq("re_throttled", (re_last - re_first) > 7, 1);
        end
    endtask

    task automatic check_quiet_outputs(input string tag);
        check_eq({tag, "_addr"}, sram_c_addr, 0);
        check_eq({tag, "_re"}, sram_c_re, 0);
        check_eq({tag, "_valid"}, out_valid, 0);
        check_eq({tag, "_data"}, out_data, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
    endtask

    initial begin
        int t0;
        int t_ab;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i * 37 + 5);
        mem[10'h010] = 8'hA1;
        mem[10'h011] = 8'hB2;
        mem[10'h012] = 8'hC3;
        mem[10'h013] = 8'hD4;
        clear_stats();

        repeat (3) @(posedge clk);
        #1;
        check_quiet_outputs("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Known-content burst, address wrap, stalled consumer, empty request.
        run_drain(10'h010, 4, 1'b0, 1'b0);
        run_drain(10'h3FE, 4, 1'b0, 1'b0);
        run_drain(10'h100, 8, 1'b1, 1'b0);
        run_drain(10'h050, 0, 1'b0, 1'b0);

        // Abort after five transfers, then a restart with abort coinciding with start.
        start_drain(10'h200, 16, 1'b0, t0);
        for (int k = 0; k < 100 && pop_cnt < 5; k++) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        t_ab  = cyc;
        abort = 1'b0;
        exp_data.delete();
        exp_addr.delete();
        repeat (4) begin
            @(posedge clk); #1;
        end
        check_eq("abort_done_pulses", done_cnt, 1);
        check_eq("abort_done_lat", done_cyc - t_ab, 0);
        check_eq("abort_transfers", pop_cnt, 6);
        check_eq("abort_valid", out_valid, 0);
        check_eq("abort_busy", busy, 0);
        run_drain(10'h020, 2, 1'b0, 1'b1);

        // Reset in the middle of a long drain.
        start_drain(10'h300, 32, 1'b0, t0);
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check_quiet_outputs("midrst");
        exp_data.delete();
        exp_addr.delete();
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_eq("midrst_no_done", done_cnt, 0);
        check_eq("midrst_idle", busy, 0);
        run_drain(10'h055, 3, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_c_drain.md
SRAM_C_DRAIN -- requirements
Module: sram_c_drain

Interface
REQ-001 Parameter: ADDR_W, default 10, SRAM C address width.
REQ-002 Parameter: DATA_W, default 8, SRAM C data width and output byte width.
REQ-003 Parameter: FIFO_DEPTH, default 4, skid buffer entries (power of two, >=4).
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse to begin a drain (driven by tile processor done).
REQ-007 base_addr  input  ADDR_W  first SRAM C address; sampled with start.
REQ-008 length  input  ADDR_W+1  byte count, 0..1024; sampled with start.
REQ-009 abort  input  1  terminates an active drain.
REQ-010 sram_c_addr  output  ADDR_W  read address to SRAM C.
REQ-011 sram_c_re  output  1  read strobe; dout valid exactly one cycle later.
REQ-012 sram_c_dout  input  DATA_W  SRAM C read data.
REQ-013 out_data  output  DATA_W  result byte toward the SPI transmit side.
REQ-014 out_valid  output  1  out_data holds a byte.
REQ-015 out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
REQ-016 busy  output  1  high from the cycle after an accepted start until done.
REQ-017 done  output  1  one-cycle pulse once the last byte transfers or abort completes.

Function
REQ-018 States: IDLE, READ (issuing reads), DRAIN (reads complete, FIFO emptying).
REQ-019 IDLE -> READ on start with length>0; IDLE -> IDLE with done pulse on the next cycle when start has length==0.
REQ-020 Start while busy is ignored; base_addr/length are not resampled.
REQ-021 READ issues sram_c_re only when FIFO occupancy + reads in flight < FIFO_DEPTH.
REQ-022 The address increments by 1 per issued read and wraps from 2^ADDR_W-1 to 0.
REQ-023 READ -> DRAIN in the cycle after the length-th read issues.
REQ-024 The captured sram_c_dout is pushed into the FIFO one cycle after its sram_c_re.
REQ-025 out_valid = FIFO non-empty; out_data = FIFO head; out_data holds stable while out_valid && !out_ready.
REQ-026 With out_ready held high, throughput is one byte per cycle sustained.
REQ-027 First-byte latency: out_valid rises 3 cycles after the start edge (read issue at T+1, capture at T+2, visible at T+3).
REQ-028 Simultaneous FIFO push and pop in one cycle leaves occupancy unchanged; the FIFO never overflows or underflows.
REQ-029 DRAIN -> IDLE with a done pulse in the cycle after the final byte transfers.
REQ-030 abort in READ/DRAIN: stop issuing reads, flush the FIFO and in-flight data, pulse done next cycle, return to IDLE; abort in IDLE is ignored.
REQ-031 abort coinciding with start in IDLE: start is honoured.
REQ-032 sram_c_re is 0 in IDLE and DRAIN.

Reset
REQ-033 rst asserted forces state IDLE, FIFO empty, in-flight count 0.
REQ-034 During reset, sram_c_addr=0, sram_c_re=0, out_valid=0, out_data=0, busy=0, done=0.
REQ-035 Reset mid-drain discards all data with no done pulse; the first clock edge after deassertion is IDLE.

Structure
REQ-036 The drain state enum and the default depth constant belong in the shared npu package.
REQ-037 The FIFO is one sub-module, sync_fifo, parameterised by width and depth, with full/empty/count outputs.

Verification
REQ-038 base=0x010, len=4, SRAM C[0x10..0x13]=A1,B2,C3,D4, ready=1 -> out_valid at start+3, bytes A1,B2,C3,D4 on 4 consecutive cycles, done at start+7.
REQ-039 base=0x3FE, len=4 -> addresses 3FE,3FF,000,001 in order, data order matches.
REQ-040 len=8, out_ready toggling 1-0 each cycle -> 8 bytes in order, no loss or duplication, sram_c_re throttled, out_data stable while stalled.
REQ-041 len=0 -> busy never rises, done pulses on the cycle after start, no sram_c_re.
REQ-042 len=16, abort after 5 transfers -> done next cycle, out_valid=0 thereafter, second start with len=2 drains correctly.
REQ-043 rst asserted mid-drain with len=32 -> all outputs 0 immediately, no done, subsequent start works.
